instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end sequencer for the 28-bit instruction set: drives the program ROM address, registers the returned instruction for decode, and consumes the control-flow opcodes `JMP` and `NOP`. `JMP` is resolved in fetch. `NOP` carries a wait count. It sits between the combinational program ROM and the execute/decode stage, and accepts stall and branch-redirect requests from execute.

## Interface
- No parameters. Opcode encodings (`NOP`, `JMP`, …) come from the shared definitions header.
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- oAddress  out  16  program counter (PC), drives ROM iAddress
- iInstruction  in  28  ROM output for oAddress, same cycle
- iStall  in  1  execute cannot accept; freeze fetch
- iBranchTaken  in  1  redirect request from execute
- iBranchAddress  in  16  redirect target
- oInstruction  out  28  registered instruction to decode
- oValid  out  1  oInstruction is a new instruction this cycle

## Operation
- Fields:
  - opcode = iInstruction[27:24]
  - JMP target = iInstruction[15:0]
  - NOP count N = iInstruction[23:0]
- Two states:
  - FETCH
  - DELAY, with a 24-bit down counter CNT.
- Reset (Reset==0 at edge):
  - PC=0, oInstruction=0, oValid=0, CNT=0, state=FETCH.
  - Reset overrides every other input, including mid-DELAY.
- Priority per edge: Reset > iBranchTaken > iStall > normal.
- iBranchTaken=1, any state:
  - PC←iBranchAddress, oValid←0, CNT←0, state←FETCH.
  - oInstruction holds its previous value.
- iStall=1 (no branch): PC, CNT, state, oInstruction, oValid all hold.
- FETCH, opcode `JMP`: PC←target, oValid←0. JMP is never forwarded.
- FETCH, opcode `NOP`: oValid←0, PC←PC+1.
  - If N>0: CNT←N, state←DELAY.
  - If N=0: stay in FETCH (single bubble). NOP is never forwarded.
- FETCH, any other opcode: oInstruction←iInstruction, oValid←1, PC←PC+1.
- DELAY:
  - oValid←0, CNT←CNT−1.
  - When CNT==1 at the edge: state←FETCH.
  - The NOP therefore costs exactly N+1 cycles of bubble in total.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000.
- ROM addresses outside the program return the default instruction. That instruction is fetched and forwarded like any other non-control opcode.

## Timing
- oAddress is combinational from the PC register.
- iInstruction is sampled at the same edge, so there is 1 cycle of latency from PC to oInstruction/oValid.
- Straight-line code gives one instruction per cycle: oValid=1 continuously with iStall=0.
- JMP costs 1 bubble cycle. The target instruction appears 2 edges after the JMP address was presented.
- oValid is a one-cycle qualifier per instruction.
- While stalled, oValid keeps its last value. Decode must treat a held oValid=1 under iStall as the same instruction, not a new one.
- Branch during DELAY aborts the delay immediately. The first fetch from the target occurs on the next cycle.
- Branch and stall together: branch wins.

## Configuration
- FETCH_NOP_DELAY_EN:
  - Defined: NOP count honored as above, and the DELAY state and CNT are present.
  - Undefined: every NOP is a single bubble regardless of N. DELAY and CNT are removed, so no 24-bit counter is synthesized.

## Test plan
- Reset then straight-line run:
  - ROM holds the `STO`,`STO`,`MUL`,`LED` sequence at addresses 1–4, with 0=`NOP` N=0.
  - Required: oAddress 0,1,2,…
  - oValid=0 at the first edge, then 1 for the four instructions in order.
  - oInstruction matches the ROM words one cycle late.
- JMP:
  - Address 7 = `JMP` target 0.
  - Required: after PC=7, oValid=0 for 1 cycle, next oAddress=0, no JMP word ever appears with oValid=1.
- NOP delay (macro defined):
  - Address 0 = `NOP` N=4000.
  - Required: oValid=0 for exactly 4001 cycles, then PC=1 fetched.
  - With the macro undefined, the same ROM gives a 1-cycle bubble.
- Stall:
  - Assert iStall for 3 cycles mid-stream.
  - Required: oAddress, oInstruction, oValid frozen for 3 cycles; fetch resumes with no instruction lost or duplicated.
- Branch vs stall vs delay:
  - In DELAY with CNT=100, assert iBranchTaken=1, iStall=1, iBranchAddress=16'h0010 together.
  - Required: next cycle oAddress=16'h0010, state FETCH, oValid=0.
- Reset mid-operation and wrap:
  - Load PC=16'hFFFF via branch, release: next oAddress=16'h0000.
  - Reset=0 during DELAY: next edge PC=0, oValid=0, oInstruction=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch sequencer: drives ROM address, resolves JMP/NOP, registers instruction.
// Build option: FETCH_NOP_DELAY_EN enables multi-cycle NOP wait counting.
package fetch_pkg;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h1;
endpackage

module instruction_fetch
    import fetch_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchAddress,
    output logic [27:0] oInstruction,
    output logic        oValid
);

    logic [15:0] pc_q, pc_d;
    logic [27:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [3:0]  opcode;
    logic        is_jmp, is_nop;

    assign opcode = iInstruction[27:24];
    assign is_jmp = (opcode == OP_JMP);
    assign is_nop = (opcode == OP_NOP);

`ifdef FETCH_NOP_DELAY_EN
    typedef enum logic {FETCH, DELAY} state_t;
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_NOP_DELAY_EN
        state_d = state_q;
        cnt_d   = cnt_q;
`endif
        if (iBranchTaken) begin
            pc_d    = iBranchAddress;
            valid_d = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            state_d = FETCH;
            cnt_d   = 24'd0;
`endif
        end else if (!iStall) begin
`ifdef FETCH_NOP_DELAY_EN
            if (state_q == DELAY) begin
                valid_d = 1'b0;
                cnt_d   = cnt_q - 24'd1;
                if (cnt_q == 24'd1)
                    state_d = FETCH;
            end else
`endif
            begin
                unique case (1'b1)
                    is_jmp: begin
                        pc_d    = iInstruction[15:0];
                        valid_d = 1'b0;
                    end
                    is_nop: begin
                        pc_d    = pc_q + 16'd1;
                        valid_d = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
                        if (iInstruction[23:0] != 24'd0) begin
                            cnt_d   = iInstruction[23:0];
                            state_d = DELAY;
                        end
`endif
                    end
                    default: begin
                        pc_d    = pc_q + 16'd1;
                        instr_d = iInstruction;
                        valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q    <= 16'd0;
            instr_q <= 28'd0;
            valid_q <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            state_q <= FETCH;
            cnt_q   <= 24'd0;
`endif
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_NOP_DELAY_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign oAddress     = pc_q;
    assign oInstruction = instr_q;
    assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized
// stimulus checked every cycle against a behavioural model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [3:0]  OP_STO = 4'h2;
    localparam logic [3:0]  OP_MUL = 4'h3;
    localparam logic [3:0]  OP_LED = 4'h4;
    localparam logic [27:0] DEF_W  = 28'hF00_0000;
`ifdef FETCH_NOP_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr;
    logic [27:0] ins_in;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] br_addr = 16'd0;
    logic [27:0] ins_out;
    logic        valid;

    logic [27:0] rom [0:255];

    int checks = 0;
    int passed = 0;
    bit cmp_on = 1'b0;

    logic [15:0] m_pc;
    logic [27:0] m_ins;
    logic        m_val;
    int          m_wait;

    instruction_fetch dut (
        .Clock(clk),
        .Reset(rst_n),
        .oAddress(addr),
        .iInstruction(ins_in),
        .iStall(stall),
        .iBranchTaken(br),
        .iBranchAddress(br_addr),
        .oInstruction(ins_out),
        .oValid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] rom_at(input logic [15:0] a);
        if (a < 16'd256) return rom[a[7:0]];
        return DEF_W;
    endfunction

    assign ins_in = rom_at(addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference behaviour: what each edge must do, from the instruction rules.
    always @(posedge clk) begin
        logic [27:0] w;
        if (!rst_n) begin
            m_pc = 16'd0; m_ins = 28'd0; m_val = 1'b0; m_wait = 0;
        end else if (br) begin
            m_pc = br_addr; m_val = 1'b0; m_wait = 0;
        end else if (stall) begin
        end else if (m_wait > 0) begin
            m_val = 1'b0; m_wait = m_wait - 1;
        end else begin
            w = rom_at(m_pc);
            if (w[27:24] == OP_JMP) begin
                m_pc = w[15:0]; m_val = 1'b0;
            end else if (w[27:24] == OP_NOP) begin
                m_pc = m_pc + 16'd1; m_val = 1'b0;
                m_wait = DELAY_EN ? int'(w[23:0]) : 0;
            end else begin
                m_pc = m_pc + 16'd1; m_ins = w; m_val = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_addr", {16'd0, addr}, {16'd0, m_pc});
            chk("cyc_ins", {4'd0, ins_out}, {4'd0, m_ins});
            chk("cyc_valid", {31'd0, valid}, {31'd0, m_val});
            if (valid === 1'b1)
                chk("ctl_forwarded", {31'd0, ins_out[27:24] == OP_JMP ||
                    ins_out[27:24] == OP_NOP}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [15:0] a);
        br = 1'b1; br_addr = a;
        step();
        br = 1'b0;
    endtask

    initial begin
        logic [27:0] prog [0:7];
        logic [15:0] h_addr;
        logic [27:0] h_ins;
        logic        h_val;
        int          bub;
        prog[0] = {OP_NOP, 24'd0};
        prog[1] = {OP_STO, 24'h000101};
        prog[2] = {OP_STO, 24'h000202};
        prog[3] = {OP_MUL, 24'h000303};
        prog[4] = {OP_LED, 24'h000404};
        prog[5] = {OP_STO, 24'h000505};
        prog[6] = {OP_MUL, 24'h000606};
        prog[7] = {OP_JMP, 24'h000000};
        for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? prog[i] : DEF_W;

        step(); step();
        cmp_on = 1'b1;
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ins", {4'd0, ins_out}, 32'd0);
        rst_n = 1'b1;

        step();
        chk("first_valid", {31'd0, valid}, 32'd0);
        chk("first_addr", {16'd0, addr}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("line_valid", {31'd0, valid}, 32'd1);
            chk("line_ins", {4'd0, ins_out}, {4'd0, prog[i]});
            chk("line_addr", {16'd0, addr}, i + 1);
        end
        step(); step();
        step();
        chk("jmp_bubble", {31'd0, valid}, 32'd0);
        chk("jmp_target", {16'd0, addr}, 32'd0);
        step(); step();
        chk("pre_stall_ins", {4'd0, ins_out}, {4'd0, prog[1]});

        h_addr = addr; h_ins = ins_out; h_val = valid;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", {16'd0, addr}, {16'd0, h_addr});
            chk("stall_ins", {4'd0, ins_out}, {4'd0, h_ins});
            chk("stall_valid", {31'd0, valid}, {31'd0, h_val});
        end
        stall = 1'b0;
        step();
        chk("resume_ins", {4'd0, ins_out}, {4'd0, prog[2]});
        chk("resume_addr", {16'd0, addr}, 32'd3);

        rom[0] = {OP_NOP, 24'd4000};
        branch_to(16'd0);
        bub = 0;
        for (int i = 0; i < 5000 && valid !== 1'b1; i++) begin
            step();
            if (valid !== 1'b1) bub++;
        end
        chk("nop_bubbles", bub, DELAY_EN ? 32'd4001 : 32'd1);
        chk("nop_next", {4'd0, ins_out}, {4'd0, prog[1]});

        rom[0] = {OP_NOP, 24'd200};
        branch_to(16'd0);
        step();
        for (int i = 0; i < 100; i++) step();
        br = 1'b1; stall = 1'b1; br_addr = 16'h0010;
        step();
        br = 1'b0; stall = 1'b0;
        chk("bsd_addr", {16'd0, addr}, 32'h10);
        chk("bsd_valid", {31'd0, valid}, 32'd0);
        step();
        chk("bsd_fetch", {4'd0, ins_out}, {4'd0, DEF_W});
        chk("bsd_fvalid", {31'd0, valid}, 32'd1);

        branch_to(16'hFFFF);
        chk("wrap_pre", {16'd0, addr}, 32'hFFFF);
        step();
        chk("wrap_addr", {16'd0, addr}, 32'd0);
        chk("wrap_ins", {4'd0, ins_out}, {4'd0, DEF_W});

        rom[0] = {OP_NOP, 24'd50};
        branch_to(16'd0);
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        step();
        chk("mrst_addr", {16'd0, addr}, 32'd0);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_ins", {4'd0, ins_out}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 5));
            if (op == OP_NOP)
                rom[i] = {OP_NOP, 24'($urandom_range(0, 5))};
            else if (op == OP_JMP)
                rom[i] = {OP_JMP, 8'h00, 16'($urandom_range(0, 70))};
            else
                rom[i] = {op, 24'($urandom)};
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            rst_n = (r != 0);
            br = (r >= 1 && r <= 4);
            stall = ($urandom_range(0, 9) == 0);
            br_addr = (r == 2) ? 16'hFFFE : 16'($urandom_range(0, 63));
            step();
        end
        rst_n = 1'b1; br = 1'b0; stall = 1'b0;
        step();
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
